mc_ctrl: RTL and testbench

- Multi-cycle MIPS control unit; next generation of the single-cycle opcode decoder.
- Moore FSM sequences fetch/decode/execute/memory/writeback over several cycles.
- Stalls on a memory-ready handshake and flags illegal opcodes.
- Sits between the instruction register (opcode) and the shared-ALU/shared-memory datapath; feeds the ALU control block via ctrlALUOp.

---
 rtl/mc_ctrl.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control unit.
// Moore FSM sequencing fetch/decode/execute/memory/writeback with memory-ready stalls.
module mc_ctrl #(
    parameter int ALUOP_W     = 3,
    parameter bit ENABLE_JUMP = 1'b1,
    parameter bit MEM_WAIT    = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               ctrlPCWrite,
    output logic               ctrlPCWriteCond,
    output logic               ctrlIorD,
    output logic               ctrlMemRead,
    output logic               ctrlMemWrite,
    output logic               ctrlIRWrite,
    output logic [1:0]         ctrlMemToReg,
    output logic [1:0]         ctrlRegDst,
    output logic               ctrlRegWrite,
    output logic               ctrlALUSrcA,
    output logic [1:0]         ctrlALUSrcB,
    output logic [ALUOP_W-1:0] ctrlALUOp,
    output logic [1:0]         ctrlPCSource,
    output logic               ctrlImmExtend,
    output logic               illegal_op,
    output logic [3:0]         state_out
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXEC    = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_IEXEC   = 4'd9;
    localparam logic [3:0] S_IWB     = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;
    localparam logic [3:0] S_ILLEGAL = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;
    localparam logic [2:0] ALU_AND   = 3'd3;
    localparam logic [2:0] ALU_OR    = 3'd4;

    // ALU class codes are 3 bits wide; ALUOP_W must be at least 3.
    function automatic logic [ALUOP_W-1:0] alu_code(input logic [2:0] code);
        logic [ALUOP_W-1:0] ext;
        ext      = '0;
        ext[2:0] = code;
        return ext;
    endfunction

    function automatic logic is_logical_imm(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI);
    endfunction

    logic [3:0]         state_r;
    logic [3:0]         state_nxt_s;
    logic               ready_s;

    logic               pc_write_s;
    logic               pc_write_cond_s;
    logic               iord_s;
    logic               mem_read_s;
    logic               mem_write_s;
    logic               ir_write_s;
    logic [1:0]         mem_to_reg_s;
    logic [1:0]         reg_dst_s;
    logic               reg_write_s;
    logic               alu_src_a_s;
    logic [1:0]         alu_src_b_s;
    logic [ALUOP_W-1:0] alu_op_s;
    logic [1:0]         pc_source_s;
    logic               imm_extend_s;
    logic               illegal_s;

    assign ready_s = MEM_WAIT ? mem_ready : 1'b1;

    // State register; reset wins over any stall in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state selection from current state, opcode and memory handshake.
    always_comb begin
        state_nxt_s = S_FETCH;
        case (state_r)
            S_FETCH: begin
                if (ready_s) begin
                    state_nxt_s = S_DECODE;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:                  state_nxt_s = S_EXEC;
                    OP_LW, OP_SW:              state_nxt_s = S_MEMADR;
                    OP_BEQ:                    state_nxt_s = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI:  state_nxt_s = S_IEXEC;
                    OP_J: begin
                        if (ENABLE_JUMP) begin
                            state_nxt_s = S_JUMP;
                        end else begin
                            state_nxt_s = S_ILLEGAL;
                        end
                    end
                    default:                   state_nxt_s = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_SW) begin
                    state_nxt_s = S_MEMWR;
                end else begin
                    state_nxt_s = S_MEMRD;
                end
            end
            S_MEMRD: begin
                if (ready_s) begin
                    state_nxt_s = S_MEMWB;
                end else begin
                    state_nxt_s = S_MEMRD;
                end
            end
            S_MEMWR: begin
                if (ready_s) begin
                    state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_MEMWR;
                end
            end
            S_EXEC:    state_nxt_s = S_ALUWB;
            S_IEXEC:   state_nxt_s = S_IWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_IWB, S_JUMP, S_ILLEGAL: state_nxt_s = S_FETCH;
            default:   state_nxt_s = S_FETCH;
        endcase
    end

    // Moore decode of the state register (FETCH also looks at the handshake).
    always_comb begin
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        iord_s          = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        ir_write_s      = 1'b0;
        mem_to_reg_s    = 2'd0;
        reg_dst_s       = 2'd0;
        reg_write_s     = 1'b0;
        alu_src_a_s     = 1'b0;
        alu_src_b_s     = 2'd0;
        alu_op_s        = alu_code(ALU_ADD);
        pc_source_s     = 2'd0;
        imm_extend_s    = 1'b1;
        illegal_s       = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_read_s  = 1'b1;
                alu_src_b_s = 2'd1;
                ir_write_s  = ready_s;
                pc_write_s  = ready_s;
            end
            S_DECODE: begin
                alu_src_b_s = 2'd3;
            end
            S_MEMADR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'd2;
            end
            S_MEMRD: begin
                mem_read_s = 1'b1;
                iord_s     = 1'b1;
            end
            S_MEMWB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 2'd1;
            end
            S_MEMWR: begin
                mem_write_s = 1'b1;
                iord_s      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = alu_code(ALU_FUNCT);
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                reg_dst_s   = 2'd1;
            end
            S_BRANCH: begin
                alu_src_a_s     = 1'b1;
                alu_op_s        = alu_code(ALU_SUB);
                pc_write_cond_s = 1'b1;
                pc_source_s     = 2'd1;
            end
            S_IEXEC: begin
                alu_src_a_s  = 1'b1;
                alu_src_b_s  = 2'd2;
                imm_extend_s = ~is_logical_imm(opcode);
                case (opcode)
                    OP_ANDI: alu_op_s = alu_code(ALU_AND);
                    OP_ORI:  alu_op_s = alu_code(ALU_OR);
                    default: alu_op_s = alu_code(ALU_ADD);
                endcase
            end
            S_IWB: begin
                reg_write_s  = 1'b1;
                imm_extend_s = ~is_logical_imm(opcode);
            end
            S_JUMP: begin
                pc_write_s  = 1'b1;
                pc_source_s = 2'd2;
            end
            S_ILLEGAL: begin
                illegal_s = 1'b1;
            end
            default: begin
                // Unused encodings: everything low, FSM recovers to FETCH.
                imm_extend_s = 1'b0;
            end
        endcase
    end

    // Output stage: reset forces every strobe low in the same cycle.
    always_comb begin
        if (rst) begin
            ctrlPCWrite     = 1'b0;
            ctrlPCWriteCond = 1'b0;
            ctrlIorD        = 1'b0;
            ctrlMemRead     = 1'b0;
            ctrlMemWrite    = 1'b0;
            ctrlIRWrite     = 1'b0;
            ctrlMemToReg    = 2'd0;
            ctrlRegDst      = 2'd0;
            ctrlRegWrite    = 1'b0;
            ctrlALUSrcA     = 1'b0;
            ctrlALUSrcB     = 2'd0;
            ctrlALUOp       = '0;
            ctrlPCSource    = 2'd0;
            ctrlImmExtend   = 1'b1;
            illegal_op      = 1'b0;
            state_out       = 4'd0;
        end else begin
            ctrlPCWrite     = pc_write_s;
            ctrlPCWriteCond = pc_write_cond_s;
            ctrlIorD        = iord_s;
            ctrlMemRead     = mem_read_s;
            ctrlMemWrite    = mem_write_s;
            ctrlIRWrite     = ir_write_s;
            ctrlMemToReg    = mem_to_reg_s;
            ctrlRegDst      = reg_dst_s;
            ctrlRegWrite    = reg_write_s;
            ctrlALUSrcA     = alu_src_a_s;
            ctrlALUSrcB     = alu_src_b_s;
            ctrlALUOp       = alu_op_s;
            ctrlPCSource    = pc_source_s;
            ctrlImmExtend   = imm_extend_s;
            illegal_op      = illegal_s;
            state_out       = state_r;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized self-checking bench for mc_ctrl against an instruction-level model.
// Instance a: jump enabled, memory handshake honoured. Instance b: jump disabled, handshake ignored.
module tb_mc_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [5:0] op_a, op_b;
    logic       rdy_a, rdy_b;

    logic       a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw, a_rw, a_srca, a_immx, a_ill;
    logic [1:0] a_m2r, a_rdst, a_srcb, a_pcsrc;
    logic [2:0] a_aluop;
    logic [3:0] a_st;

    logic       b_pcw, b_pcwc, b_iord, b_mrd, b_mwr, b_irw, b_rw, b_srca, b_immx, b_ill;
    logic [1:0] b_m2r, b_rdst, b_srcb, b_pcsrc;
    logic [3:0] b_aluop;
    logic [3:0] b_st;

    int tests_run    = 0;
    int tests_failed = 0;
    int path_q[$];

    mc_ctrl #(.ALUOP_W(3), .ENABLE_JUMP(1'b1), .MEM_WAIT(1'b1)) dut_a (
        .clk(clk), .rst(rst), .opcode(op_a), .mem_ready(rdy_a),
        .ctrlPCWrite(a_pcw), .ctrlPCWriteCond(a_pcwc), .ctrlIorD(a_iord),
        .ctrlMemRead(a_mrd), .ctrlMemWrite(a_mwr), .ctrlIRWrite(a_irw),
        .ctrlMemToReg(a_m2r), .ctrlRegDst(a_rdst), .ctrlRegWrite(a_rw),
        .ctrlALUSrcA(a_srca), .ctrlALUSrcB(a_srcb), .ctrlALUOp(a_aluop),
        .ctrlPCSource(a_pcsrc), .ctrlImmExtend(a_immx), .illegal_op(a_ill),
        .state_out(a_st)
    );

    mc_ctrl #(.ALUOP_W(4), .ENABLE_JUMP(1'b0), .MEM_WAIT(1'b0)) dut_b (
        .clk(clk), .rst(rst), .opcode(op_b), .mem_ready(rdy_b),
        .ctrlPCWrite(b_pcw), .ctrlPCWriteCond(b_pcwc), .ctrlIorD(b_iord),
        .ctrlMemRead(b_mrd), .ctrlMemWrite(b_mwr), .ctrlIRWrite(b_irw),
        .ctrlMemToReg(b_m2r), .ctrlRegDst(b_rdst), .ctrlRegWrite(b_rw),
        .ctrlALUSrcA(b_srca), .ctrlALUSrcB(b_srcb), .ctrlALUOp(b_aluop),
        .ctrlPCSource(b_pcsrc), .ctrlImmExtend(b_immx), .illegal_op(b_ill),
        .state_out(b_st)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_a();
        return {6'd0, a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw, a_m2r, a_rdst, a_rw,
                a_srca, a_srcb, {1'b0, a_aluop}, a_pcsrc, a_immx, a_ill, a_st};
    endfunction

    function automatic logic [31:0] obs_b();
        return {6'd0, b_pcw, b_pcwc, b_iord, b_mrd, b_mwr, b_irw, b_m2r, b_rdst, b_rw,
                b_srca, b_srcb, b_aluop, b_pcsrc, b_immx, b_ill, b_st};
    endfunction

    // Control word the specification lists for each state (same packing as obs_a/obs_b).
    function automatic logic [31:0] exp_ctl(input int st, input logic [5:0] op, input bit rdy, input bit rst_on);
        logic       pcw, pcwc, iord, mrd, mwr, irw, rw, srca, immx, ill;
        logic [1:0] m2r, rdst, srcb, pcsrc;
        logic [3:0] aop, s;
        bit         logic_imm;
        pcw = 1'b0; pcwc = 1'b0; iord = 1'b0; mrd = 1'b0; mwr = 1'b0; irw = 1'b0;
        rw = 1'b0; srca = 1'b0; immx = 1'b1; ill = 1'b0;
        m2r = 2'd0; rdst = 2'd0; srcb = 2'd0; pcsrc = 2'd0; aop = 4'd0;
        s = rst_on ? 4'd0 : 4'(st);
        logic_imm = (op == 6'h0C) || (op == 6'h0D);
        if (!rst_on) begin
            case (st)
                0:  begin mrd = 1'b1; srcb = 2'd1; pcw = rdy; irw = rdy; end
                1:  srcb = 2'd3;
                2:  begin srca = 1'b1; srcb = 2'd2; end
                3:  begin mrd = 1'b1; iord = 1'b1; end
                4:  begin rw = 1'b1; m2r = 2'd1; end
                5:  begin mwr = 1'b1; iord = 1'b1; end
                6:  begin srca = 1'b1; aop = 4'd2; end
                7:  begin rw = 1'b1; rdst = 2'd1; end
                8:  begin srca = 1'b1; aop = 4'd1; pcwc = 1'b1; pcsrc = 2'd1; end
                9:  begin
                        srca = 1'b1; srcb = 2'd2; immx = !logic_imm;
                        aop = (op == 6'h0C) ? 4'd3 : ((op == 6'h0D) ? 4'd4 : 4'd0);
                    end
                10: begin rw = 1'b1; immx = !logic_imm; end
                11: begin pcw = 1'b1; pcsrc = 2'd2; end
                12: ill = 1'b1;
                default: ;
            endcase
        end
        return {6'd0, pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, pcsrc, immx, ill, s};
    endfunction

    // Sequence of states an instruction walks through, from the instruction table.
    function automatic void build_path(input int which, input logic [5:0] op);
        path_q.delete();
        path_q.push_back(0);
        path_q.push_back(1);
        case (op)
            6'h00: begin path_q.push_back(6); path_q.push_back(7); end
            6'h23: begin path_q.push_back(2); path_q.push_back(3); path_q.push_back(4); end
            6'h2B: begin path_q.push_back(2); path_q.push_back(5); end
            6'h04: path_q.push_back(8);
            6'h08, 6'h0C, 6'h0D: begin path_q.push_back(9); path_q.push_back(10); end
            6'h02: path_q.push_back((which == 0) ? 11 : 12);
            default: path_q.push_back(12);
        endcase
    endfunction

    // One clock: drive just after the rising edge, check at the falling edge.
    task automatic cyc(input int which, input int st, input logic [5:0] op, input bit rdy,
                       input bit rst_on, input string tag);
        logic [5:0] op_drv;
        bit         eff;
        op_drv = (st == 0) ? 6'($urandom) : op;
        rst = rst_on;
        if (which == 0) begin
            op_a = op_drv; rdy_a = rdy;
        end else begin
            op_b = op_drv; rdy_b = rdy;
        end
        eff = (which == 0) ? rdy : 1'b1;
        #4;
        if (rst_on) begin
            check_eq($sformatf("%s/a", tag), obs_a(), exp_ctl(0, op, 1'b0, 1'b1));
            check_eq($sformatf("%s/b", tag), obs_b(), exp_ctl(0, op, 1'b0, 1'b1));
        end else if (which == 0) begin
            check_eq($sformatf("%s/a st=%0d op=%h", tag, st, op), obs_a(), exp_ctl(st, op, eff, 1'b0));
        end else begin
            check_eq($sformatf("%s/b st=%0d op=%h", tag, st, op), obs_b(), exp_ctl(st, op, eff, 1'b0));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input int which, input logic [5:0] op, input int fstall, input int mstall);
        int st;
        int stall;
        build_path(which, op);
        foreach (path_q[k]) begin
            st = path_q[k];
            if (st == 0 || st == 3 || st == 5) begin
                stall = (st == 0) ? fstall : mstall;
                if (which == 0) begin
                    for (int c = 0; c < stall; c++) cyc(which, st, op, 1'b0, 1'b0, "stall");
                    cyc(which, st, op, 1'b1, 1'b0, "ready");
                end else begin
                    cyc(which, st, op, (stall > 0) ? 1'b0 : 1'b1, 1'b0, "noready");
                end
            end else begin
                cyc(which, st, op, 1'($urandom), 1'b0, "step");
            end
        end
    endtask

    task automatic do_reset();
        cyc(0, 0, 6'h00, 1'b0, 1'b1, "reset");
        cyc(0, 0, 6'h00, 1'b1, 1'b1, "reset");
    endtask

    logic [5:0] op_tbl [9] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h02, 6'h3F};

    initial begin
        logic [5:0] op;
        rst = 1'b1; op_a = 6'h00; op_b = 6'h00; rdy_a = 1'b0; rdy_b = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Directed sequences on instance a.
        run_instr(0, 6'h00, 0, 0);
        run_instr(0, 6'h23, 0, 3);
        run_instr(0, 6'h2B, 2, 0);
        run_instr(0, 6'h0D, 0, 0);
        run_instr(0, 6'h08, 0, 0);
        run_instr(0, 6'h0C, 1, 0);
        run_instr(0, 6'h04, 0, 0);
        run_instr(0, 6'h3F, 0, 0);
        run_instr(0, 6'h02, 0, 0);

        // Reset in the middle of a store stall.
        cyc(0, 0, 6'h2B, 1'b1, 1'b0, "sw_fetch");
        cyc(0, 1, 6'h2B, 1'b0, 1'b0, "sw_decode");
        cyc(0, 2, 6'h2B, 1'b0, 1'b0, "sw_memadr");
        cyc(0, 5, 6'h2B, 1'b0, 1'b0, "sw_stall");
        cyc(0, 5, 6'h2B, 1'b0, 1'b1, "rst_in_memwr");
        run_instr(0, 6'h2B, 1, 1);

        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : op_tbl[$urandom_range(0, 8)];
            run_instr(0, op, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Instance b: jump disabled, handshake ignored.
        do_reset();
        run_instr(1, 6'h02, 0, 0);
        run_instr(1, 6'h23, 2, 2);
        run_instr(1, 6'h2B, 1, 3);
        run_instr(1, 6'h0D, 0, 0);
        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : op_tbl[$urandom_range(0, 8)];
            run_instr(1, op, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
